// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, ALU command encodings and pipeline record types for the MIPS-lab ID/EXE slice.
package mips_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd3;
    localparam logic [5:0] OP_AND  = 6'd5;
    localparam logic [5:0] OP_OR   = 6'd6;
    localparam logic [5:0] OP_NOR  = 6'd7;
    localparam logic [5:0] OP_XOR  = 6'd8;
    localparam logic [5:0] OP_SLA  = 6'd9;
    localparam logic [5:0] OP_SLL  = 6'd10;
    localparam logic [5:0] OP_SRA  = 6'd11;
    localparam logic [5:0] OP_SRL  = 6'd12;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    typedef enum logic [3:0] {
        CMD_ADD = 4'b0000,
        CMD_SUB = 4'b0010,
        CMD_AND = 4'b0100,
        CMD_OR  = 4'b0101,
        CMD_NOR = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SHL = 4'b1000,
        CMD_SRA = 4'b1001,
        CMD_SRL = 4'b1010
    } exe_cmd_e;

    typedef struct packed {
        logic     wb_en;
        logic     mem_r_en;
        logic     mem_w_en;
        exe_cmd_e cmd;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] val1;
        logic [XLEN-1:0] val2;
        logic [XLEN-1:0] reg2;
        logic [XLEN-1:0] pc;
        logic [4:0]      dest;
        ctrl_t           ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] st;
        logic [XLEN-1:0] pc;
        logic [4:0]      dest;
        logic            wb_en;
        logic            mem_r_en;
        logic            mem_w_en;
    } ex_mem_t;

    // Undefined opcodes fall through to the NOP encoding (add, no side effects).
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t d;
        d = '{wb_en: 1'b0, mem_r_en: 1'b0, mem_w_en: 1'b0, cmd: CMD_ADD};
        case (op)
            OP_ADD, OP_ADDI: d.wb_en = 1'b1;
            OP_SUB, OP_SUBI: begin d.cmd = CMD_SUB; d.wb_en = 1'b1; end
            OP_AND:          begin d.cmd = CMD_AND; d.wb_en = 1'b1; end
            OP_OR:           begin d.cmd = CMD_OR;  d.wb_en = 1'b1; end
            OP_NOR:          begin d.cmd = CMD_NOR; d.wb_en = 1'b1; end
            OP_XOR:          begin d.cmd = CMD_XOR; d.wb_en = 1'b1; end
            OP_SLA, OP_SLL:  begin d.cmd = CMD_SHL; d.wb_en = 1'b1; end
            OP_SRA:          begin d.cmd = CMD_SRA; d.wb_en = 1'b1; end
            OP_SRL:          begin d.cmd = CMD_SRL; d.wb_en = 1'b1; end
            OP_LD:           begin d.wb_en = 1'b1; d.mem_r_en = 1'b1; end
            OP_ST:           d.mem_w_en = 1'b1;
            default:         ;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/mips_alu.sv
// mips_alu: 32-bit wrap-around ALU driven by the EXE_CMD code, no flags.
module mips_alu
    import mips_pkg::*;
(
    input  logic [3:0]      i_cmd,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result
);
    always_comb begin
        case (i_cmd)
            CMD_ADD: o_result = i_a + i_b;
            CMD_SUB: o_result = i_a - i_b;
            CMD_AND: o_result = i_a & i_b;
            CMD_OR:  o_result = i_a | i_b;
            CMD_NOR: o_result = ~(i_a | i_b);
            CMD_XOR: o_result = i_a ^ i_b;
            CMD_SHL: o_result = i_a << i_b[4:0];
            CMD_SRA: o_result = $unsigned($signed(i_a) >>> i_b[4:0]);
            CMD_SRL: o_result = i_a >> i_b[4:0];
            default: o_result = '0;
        endcase
    end
endmodule

// File: rtl/id_exe_core.sv
// id_exe_core: decode (register file, control, branch resolution) plus ID/EX, ALU and EX/MEM registers.
module id_exe_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      wb_dest,
    input  logic            wb_we,
    output logic            br_taken,
    output logic [XLEN-1:0] br_addr,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] st_val,
    output logic [4:0]      dest,
    output logic            mem_r_en,
    output logic            mem_w_en,
    output logic            wb_en,
    output logic [XLEN-1:0] pc_out
);
    import mips_pkg::*;

    logic [XLEN-1:0] r_rf [NREGS];
    id_ex_t          r_id_ex;
    ex_mem_t         r_ex_mem;

    logic [5:0]      w_op;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [XLEN-1:0] w_sext;
    logic            w_reg2_rd;
    logic            w_use_imm;
    logic [XLEN-1:0] w_val1;
    logic [XLEN-1:0] w_reg2;
    logic [XLEN-1:0] w_val2;
    ctrl_t           w_ctrl;
    logic [XLEN-1:0] w_alu;

    // Write-through read: a same-cycle write-back is visible to decode.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        return (idx == 5'd0) ? '0 : (wb_we && wb_dest == idx) ? wb_data : r_rf[idx];
    endfunction

    assign w_op      = instr[31:26];
    assign w_rd      = instr[25:21];
    assign w_rs      = instr[20:16];
    assign w_rt      = instr[15:11];
    assign w_sext    = {{(XLEN-16){instr[15]}}, instr[15:0]};
    assign w_reg2_rd = (w_op == OP_ST) || (w_op == OP_BEZ) || (w_op == OP_BNE);
    assign w_use_imm = (w_op == OP_ADDI) || (w_op == OP_SUBI) || (w_op == OP_LD) || (w_op == OP_ST);
    assign w_val1    = rf_read(w_rs);
    assign w_reg2    = rf_read(w_reg2_rd ? w_rd : w_rt);
    assign w_val2    = w_use_imm ? w_sext : w_reg2;
    assign w_ctrl    = decode(w_op);

    assign br_taken = (w_op == OP_BEZ) ? (w_val1 == '0) :
                      (w_op == OP_BNE) ? (w_val1 != w_reg2) :
                      (w_op == OP_JMP);
    assign br_addr  = pc_in + {w_sext[XLEN-3:0], 2'b00};

    // Contents are not reset; R0 is never written and reads as zero.
    always_ff @(posedge clk) begin
        if (wb_we && wb_dest != 5'd0)
            r_rf[wb_dest] <= wb_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id_ex  <= '0;
            r_ex_mem <= '0;
        end else begin
            r_id_ex  <= '{val1: w_val1, val2: w_val2, reg2: w_reg2, pc: pc_in, dest: w_rd, ctrl: w_ctrl};
            r_ex_mem <= '{alu: w_alu, st: r_id_ex.reg2, pc: r_id_ex.pc, dest: r_id_ex.dest,
                          wb_en: r_id_ex.ctrl.wb_en, mem_r_en: r_id_ex.ctrl.mem_r_en,
                          mem_w_en: r_id_ex.ctrl.mem_w_en};
        end
    end

    mips_alu u_alu (
        .i_cmd    (r_id_ex.ctrl.cmd),
        .i_a      (r_id_ex.val1),
        .i_b      (r_id_ex.val2),
        .o_result (w_alu)
    );

    assign alu_result = r_ex_mem.alu;
    assign st_val     = r_ex_mem.st;
    assign dest       = r_ex_mem.dest;
    assign mem_r_en   = r_ex_mem.mem_r_en;
    assign mem_w_en   = r_ex_mem.mem_w_en;
    assign wb_en      = r_ex_mem.wb_en;
    assign pc_out     = r_ex_mem.pc;
endmodule

// File: tb/tb_id_exe_core.sv
// tb_id_exe_core: directed and random stimulus against an opcode-level model of decode+execute.
module tb_id_exe_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  wb_dest = '0;
    logic        wb_we = 1'b0;
    logic        br_taken;
    logic [31:0] br_addr;
    logic [31:0] alu_result;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic [31:0] pc_out;

    id_exe_core dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instr(instr), .wb_data(wb_data),
        .wb_dest(wb_dest), .wb_we(wb_we), .br_taken(br_taken), .br_addr(br_addr),
        .alu_result(alu_result), .st_val(st_val), .dest(dest), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .wb_en(wb_en), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] st;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
    } exp_t;

    logic [31:0] m_rf [32];
    exp_t        s1, s2;
    bit          cmp_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mread(input logic [4:0] i);
        if (i == 5'd0) return 32'd0;
        if (wb_we && wb_dest == i) return wb_data;
        return m_rf[i];
    endfunction

    function automatic logic [31:0] m_reg2();
        logic [5:0] op = instr[31:26];
        return (op == 6'd37 || op == 6'd40 || op == 6'd41) ? mread(instr[25:21]) : mread(instr[15:11]);
    endfunction

    function automatic exp_t model();
        exp_t        e;
        logic [5:0]  op = instr[31:26];
        logic [31:0] a  = mread(instr[20:16]);
        logic [31:0] r2 = m_reg2();
        logic [31:0] sx = {{16{instr[15]}}, instr[15:0]};
        e = '{default: 0};
        e.dest = instr[25:21];
        e.pc   = pc_in;
        e.st   = r2;
        e.alu  = a + r2;
        case (op)
            6'd1:        begin e.alu = a + r2; e.wb = 1'b1; end
            6'd3:        begin e.alu = a - r2; e.wb = 1'b1; end
            6'd5:        begin e.alu = a & r2; e.wb = 1'b1; end
            6'd6:        begin e.alu = a | r2; e.wb = 1'b1; end
            6'd7:        begin e.alu = ~(a | r2); e.wb = 1'b1; end
            6'd8:        begin e.alu = a ^ r2; e.wb = 1'b1; end
            6'd9, 6'd10: begin e.alu = a << r2[4:0]; e.wb = 1'b1; end
            6'd11:       begin e.alu = $unsigned($signed(a) >>> r2[4:0]); e.wb = 1'b1; end
            6'd12:       begin e.alu = a >> r2[4:0]; e.wb = 1'b1; end
            6'd32:       begin e.alu = a + sx; e.wb = 1'b1; end
            6'd33:       begin e.alu = a - sx; e.wb = 1'b1; end
            6'd36:       begin e.alu = a + sx; e.wb = 1'b1; e.mr = 1'b1; end
            6'd37:       begin e.alu = a + sx; e.mw = 1'b1; end
            default:     ;
        endcase
        return e;
    endfunction

    function automatic logic m_taken();
        logic [5:0] op = instr[31:26];
        if (op == 6'd40) return mread(instr[20:16]) == 32'd0;
        if (op == 6'd41) return mread(instr[20:16]) != m_reg2();
        return op == 6'd42;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("alu_result", alu_result, s2.alu);
            chk("st_val", st_val, s2.st);
            chk("dest", {27'd0, dest}, {27'd0, s2.dest});
            chk("wb_en", {31'd0, wb_en}, {31'd0, s2.wb});
            chk("mem_r_en", {31'd0, mem_r_en}, {31'd0, s2.mr});
            chk("mem_w_en", {31'd0, mem_w_en}, {31'd0, s2.mw});
            chk("pc_out", pc_out, s2.pc);
            chk("br_taken", {31'd0, br_taken}, {31'd0, m_taken()});
            chk("br_addr", br_addr, pc_in + {instr[15] ? 14'h3FFF : 14'h0, instr[15:0], 2'b00});
        end
    end

    task automatic step(input logic r, input logic [31:0] ins, input logic [31:0] pc,
                        input logic we, input logic [4:0] wd, input logic [31:0] wdat);
        exp_t e;
        rst = r; instr = ins; pc_in = pc; wb_we = we; wb_dest = wd; wb_data = wdat;
        e = model();
        @(posedge clk);
        if (!r) begin
            s1 = '{default: 0};
            s2 = '{default: 0};
        end else begin
            s2 = s1;
            s1 = e;
        end
        if (we && wd != 5'd0) m_rf[wd] = wdat;
        #1;
    endtask

    task automatic nop_wb(input int d, input logic [31:0] v);
        step(1'b1, 32'd0, 32'd0, 1'b1, d[4:0], v);
    endtask

    task automatic iss(input logic [31:0] ins);
        step(1'b1, ins, 32'h40, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic br_lit(input string n, input logic [31:0] ins, input logic exp_t_, input logic [31:0] exp_a);
        instr = ins; pc_in = 32'h100; wb_we = 1'b0; rst = 1'b1;
        #2;
        chk({n, "_taken"}, {31'd0, br_taken}, {31'd0, exp_t_});
        chk({n, "_addr"}, br_addr, exp_a);
        step(1'b1, ins, 32'h100, 1'b0, 5'd0, 32'd0);
    endtask

    function automatic logic [31:0] R(input int op, input int rd, input int rs, input int rt);
        return {op[5:0], rd[4:0], rs[4:0], rt[4:0], 11'd0};
    endfunction

    function automatic logic [31:0] I(input int op, input int rd, input int rs, input int imm);
        return {op[5:0], rd[4:0], rs[4:0], imm[15:0]};
    endfunction

    int ops [18] = '{0, 1, 3, 5, 6, 7, 8, 9, 10, 11, 12, 32, 33, 36, 37, 40, 41, 42};

    initial begin
        m_rf[0] = 32'd0;
        s1 = '{default: 0};
        s2 = '{default: 0};
        for (int i = 0; i < 32; i++) step(1'b0, 32'd0, 32'd0, 1'b1, i[4:0], $urandom);
        cmp_en = 1'b1;
        chk("rst_alu", alu_result, 32'd0);
        chk("rst_dest", {27'd0, dest}, 32'd0);
        chk("rst_ctrl", {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);

        nop_wb(1, 32'd7);
        nop_wb(2, 32'd5);
        iss(R(1, 3, 1, 2));
        iss(R(3, 3, 1, 2));
        chk("add_res", alu_result, 32'd12);
        chk("add_dest", {27'd0, dest}, 32'd3);
        chk("add_wb", {31'd0, wb_en}, 32'd1);
        iss(R(7, 3, 1, 2));
        chk("sub_res", alu_result, 32'd2);
        iss(32'd0);
        chk("nor_res", alu_result, 32'hFFFF_FFF8);

        iss(I(32, 4, 1, 16'hFFFF));
        iss(I(36, 5, 1, 8));
        chk("addi_res", alu_result, 32'd6);
        nop_wb(6, 32'hAB);
        chk("ld_res", alu_result, 32'd15);
        chk("ld_mr", {31'd0, mem_r_en}, 32'd1);
        iss(I(37, 6, 1, 0));
        iss(32'd0);
        chk("st_val", st_val, 32'hAB);
        chk("st_mw", {31'd0, mem_w_en}, 32'd1);
        chk("st_wb", {31'd0, wb_en}, 32'd0);

        nop_wb(1, 32'h8000_0000);
        nop_wb(2, 32'd4);
        iss(R(11, 3, 1, 2));
        iss(R(12, 3, 1, 2));
        chk("sra_res", alu_result, 32'hF800_0000);
        iss(R(10, 3, 1, 2));
        chk("srl_res", alu_result, 32'h0800_0000);
        iss(32'd0);
        chk("sll_res", alu_result, 32'd0);

        nop_wb(1, 32'd0);
        br_lit("bez", I(40, 0, 1, 3), 1'b1, 32'h10C);
        br_lit("bne", I(41, 1, 1, 3), 1'b0, 32'h10C);
        br_lit("jmp", I(42, 0, 0, 3), 1'b1, 32'h10C);

        nop_wb(0, 32'd5);
        iss(R(1, 3, 0, 0));
        iss(32'd0);
        chk("r0_res", alu_result, 32'd0);
        step(1'b1, R(1, 3, 4, 0), 32'd0, 1'b1, 5'd4, 32'h55);
        iss(32'd0);
        chk("bypass_res", alu_result, 32'h55);

        iss(R(1, 3, 1, 2));
        step(1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        chk("midrst_alu", alu_result, 32'd0);
        chk("midrst_dest", {27'd0, dest}, 32'd0);
        iss(R(1, 3, 7, 0));
        iss(32'd0);
        chk("rst_write", alu_result, 32'h1234);

        for (int n = 0; n < 3000; n++) begin
            int          o;
            logic [31:0] rnd;
            logic [31:0] wd;
            rnd = $urandom;
            wd  = $urandom;
            o   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : ops[$urandom_range(0, 17)];
            step($urandom_range(0, 49) != 0, {o[5:0], rnd[25:0]}, $urandom, $urandom_range(0, 1) == 1,
                 wd[4:0], ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_exe_core.md
Name: id_exe_core

Overview:
- Decode plus execute slice of the 5-stage MIPS-lab pipeline: instruction decode, 32x32 register file, control unit and branch resolution (ID), then the ID/EX register, ALU (EXE) and the EX/MEM register.
- Sits between the IF/ID register and the MEM stage.
- Receives write-back traffic from the WB stage.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register-file depth (5-bit index).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  reset; active-low, synchronous.
- pc_in  in  32  PC+4 of the instruction in decode.
- instr  in  32  instruction in decode.
- wb_data  in  32  write-back value.
- wb_dest  in  5  write-back register index.
- wb_we  in  1  write-back enable.
- br_taken  out  1  combinational; branch/jump resolved in ID.
- br_addr  out  32  combinational; pc_in + (sext(imm16) << 2).
- alu_result  out  32  registered EX/MEM ALU result (memory address for LD/ST).
- st_val  out  32  registered store data (Reg2).
- dest  out  5  registered destination index.
- mem_r_en, mem_w_en, wb_en  out  1 each  registered control bits.
- pc_out  out  32  registered PC, passed through.

Behaviour:
- Instruction fields: opcode = instr[31:26], rd = [25:21], rs = [20:16], rt = [15:11], imm = [15:0]. sext = 16-to-32-bit sign extension.
- Register file:
  - R0 reads 0 and ignores writes.
  - Write at the rising edge when wb_we=1.
  - Same-cycle read of wb_dest returns wb_data (write-through bypass).
  - No reset of contents except that R0 is always 0.
- Val1 = RF[rs].
- Reg2 = RF[rt] for R-type; RF[rd] for ST, BNE and BEZ.
- Val2 = sext(imm) for ADDI, SUBI, LD and ST; Reg2 otherwise.
- Opcode decode (opcode: EXE_CMD, wb_en, mem_r_en, mem_w_en):
  - 0 NOP: 0000, 0, 0, 0.
  - 1 ADD: 0000, 1, 0, 0.
  - 3 SUB: 0010, 1, 0, 0.
  - 5 AND: 0100, 1, 0, 0.
  - 6 OR: 0101, 1, 0, 0.
  - 7 NOR: 0110, 1, 0, 0.
  - 8 XOR: 0111, 1, 0, 0.
  - 9 SLA and 10 SLL: 1000, 1, 0, 0.
  - 11 SRA: 1001, 1, 0, 0.
  - 12 SRL: 1010, 1, 0, 0.
  - 32 ADDI: 0000, 1, 0, 0.
  - 33 SUBI: 0010, 1, 0, 0.
  - 36 LD: 0000, 1, 1, 0.
  - 37 ST: 0000, 0, 0, 1.
  - 40 BEZ, 41 BNE, 42 JMP: no write-back, no memory access.
  - Any undefined opcode behaves as NOP.
- Branch resolution, combinational in ID:
  - BEZ taken iff Val1 == 0.
  - BNE taken iff Val1 != Reg2.
  - JMP always taken.
  - All other opcodes: br_taken = 0.
- Flushing the fetched instruction on br_taken is the fetch side's responsibility.
- ID/EX register: latches Val1, Val2, Reg2, EXE_CMD, rd, control bits and PC every clock.
- ALU (EXE), 32-bit, wrap-around, no flags:
  - 0000: a + b.
  - 0010: a − b.
  - 0100: a & b.
  - 0101: a | b.
  - 0110: ~(a | b).
  - 0111: a ^ b.
  - 1000: a << b[4:0].
  - 1001: arithmetic >> b[4:0].
  - 1010: logical >> b[4:0].
  - Other codes give 0.
- EX/MEM register: latches ALU result, Reg2 (as st_val), dest, control bits and PC.
- Latency: an instruction's outputs appear at the EX/MEM outputs 2 rising edges after it is presented on instr.
- Reset (rst=0 sampled at an edge): both pipeline registers clear all fields to 0 (NOP bubble). Reset mid-stream discards in-flight instructions.
- wb_we is honoured during reset: a write to Rn≠0 still occurs.
- No hazard detection or forwarding in this block.

Decomposition:
- Shared package mips_pkg: opcode constants, EXE_CMD encodings, XLEN.
- One natural sub-module: mips_alu (EXE_CMD, a, b → result).
- Register file, control decode and pipeline registers stay in id_exe_core.

Test Plan:
- Reset: hold rst=0 for 2 edges → alu_result=0, dest=0, wb_en=mem_r_en=mem_w_en=0, pc_out=0.
- ALU path:
  - WB-write R1=7, R2=5.
  - ADD rd=3, rs=1, rt=2 → after 2 edges: alu_result=12, dest=3, wb_en=1.
  - SUB → 2; NOR R1,R2 → 0xFFFFFFF8.
- Immediate and memory ops:
  - ADDI imm=0xFFFF on R1=7 → 6.
  - LD imm=8, rs=R1 → alu_result=15, mem_r_en=1.
  - ST with RF[rd]=0xAB → st_val=0xAB, mem_w_en=1, wb_en=0.
- Shifts with R1=0x80000000, b=4:
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - SLL → 0.
- Branches with pc_in=0x100, imm=3:
  - BEZ with R1=0 → br_taken=1, br_addr=0x10C.
  - BNE with equal operands → br_taken=0.
  - JMP → br_taken=1.
- Register-file edge cases:
  - Write R0=5 then read R0 → 0.
  - Same-cycle write R4=0x55 while decoding a read of R4 → Val1 sees 0x55.
